// File: rtl/region_fit_classifier.sv
// Streaming region classifier: 3-stage pipeline sorting regions into FIT / FAIL / UNDECIDED
// with one saturating counter per class. Optional per-region output port under REGION_CLASS_OUT_EN.
module region_fit_classifier #(
  parameter int NUM_SHAPES = 6,
  parameter int QTY_W      = 8,
  parameter int DIM_W      = 8,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_SHAPES*4-1:0]     shape_cells,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [DIM_W-1:0]            in_width,
  input  logic [DIM_W-1:0]            in_height,
  input  logic [NUM_SHAPES*QTY_W-1:0] in_qty,
  output logic                        busy,
  output logic                        finished,
  output logic [CNT_W-1:0]            result,
  output logic [CNT_W-1:0]            fail_count,
  output logic [CNT_W-1:0]            undecided_count,
`ifdef REGION_CLASS_OUT_EN
  output logic                        out_valid,
  output logic [1:0]                  out_class,
  output logic [CNT_W-1:0]            out_index,
`endif
  output logic [1:0]                  state_dbg
);

  localparam int SUM_W  = QTY_W + $clog2(NUM_SHAPES) + 4;
  localparam int PROD_W = 2 * DIM_W;
  localparam int CMP_W  = (SUM_W > PROD_W) ? SUM_W : PROD_W;

  localparam logic [1:0] CLS_FIT  = 2'd0;
  localparam logic [1:0] CLS_FAIL = 2'd1;
  localparam logic [1:0] CLS_UND  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [NUM_SHAPES*4-1:0] cells_q;

  // Stage 1 registers
  logic                    s1_valid;
  logic [SUM_W-1:0]        s1_qty_sum;
  logic [SUM_W-1:0]        s1_weighted;
  logic [PROD_W-1:0]       s1_cap;
  logic [PROD_W-1:0]       s1_area;

  // Stage 2 registers
  logic                    s2_valid;
  logic [1:0]              s2_class;

  logic [SUM_W-1:0]        qty_sum_c;
  logic [SUM_W-1:0]        weighted_c;
  logic [PROD_W-1:0]       cap_c;
  logic [PROD_W-1:0]       area_c;
  logic [1:0]              class_c;
  logic                    accept;

`ifdef REGION_CLASS_OUT_EN
  logic [CNT_W-1:0]        region_idx;
`endif

  assign in_ready  = (state == ST_RUN);
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign state_dbg = state;
  assign accept    = in_valid && in_ready;

  always_comb begin
    qty_sum_c  = '0;
    weighted_c = '0;
    for (int i = 0; i < NUM_SHAPES; i++) begin
      qty_sum_c  = qty_sum_c + SUM_W'(in_qty[QTY_W*i +: QTY_W]);
      weighted_c = weighted_c
                 + SUM_W'(in_qty[QTY_W*i +: QTY_W]) * SUM_W'(cells_q[4*i +: 4]);
    end
  end

  assign cap_c  = PROD_W'(in_width / DIM_W'(3)) * PROD_W'(in_height / DIM_W'(3));
  assign area_c = PROD_W'(in_width) * PROD_W'(in_height);

  always_comb begin
    class_c = CLS_UND;
    if (CMP_W'(s1_qty_sum) <= CMP_W'(s1_cap))
      class_c = CLS_FIT;
    else if (CMP_W'(s1_weighted) > CMP_W'(s1_area))
      class_c = CLS_FAIL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= ST_IDLE;
      cells_q         <= '0;
      finished        <= 1'b0;
      s1_valid        <= 1'b0;
      s1_qty_sum      <= '0;
      s1_weighted     <= '0;
      s1_cap          <= '0;
      s1_area         <= '0;
      s2_valid        <= 1'b0;
      s2_class        <= CLS_FIT;
      result          <= '0;
      fail_count      <= '0;
      undecided_count <= '0;
`ifdef REGION_CLASS_OUT_EN
      out_valid       <= 1'b0;
      out_class       <= 2'd0;
      out_index       <= '0;
      region_idx      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state           <= ST_RUN;
            cells_q         <= shape_cells;
            finished        <= 1'b0;
            result          <= '0;
            fail_count      <= '0;
            undecided_count <= '0;
`ifdef REGION_CLASS_OUT_EN
            region_idx      <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (accept && in_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // The entry just leaving stage 2 is counted on this same edge.
          if (!s1_valid && !s2_valid) begin
            state    <= ST_DONE;
            finished <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      s1_valid <= accept;
      if (accept) begin
        s1_qty_sum  <= qty_sum_c;
        s1_weighted <= weighted_c;
        s1_cap      <= cap_c;
        s1_area     <= area_c;
      end

      s2_valid <= s1_valid;
      if (s1_valid) s2_class <= class_c;

      if (s2_valid) begin
        case (s2_class)
          CLS_FIT:  if (result != '1)          result          <= result + CNT_W'(1);
          CLS_FAIL: if (fail_count != '1)      fail_count      <= fail_count + CNT_W'(1);
          default:  if (undecided_count != '1) undecided_count <= undecided_count + CNT_W'(1);
        endcase
      end

`ifdef REGION_CLASS_OUT_EN
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_class  <= s2_class;
        out_index  <= region_idx;
        region_idx <= region_idx + CNT_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_region_fit_classifier.sv
// Directed bench for region_fit_classifier: hand-computed small runs plus a bulk run
// scored against a small classification model.
module tb_region_fit_classifier;

  localparam int NS = 6;
  localparam int QW = 8;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int NV = 1010;

  logic              clk;
  logic              rst;
  logic              start;
  logic [NS*4-1:0]   shape_cells;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DW-1:0]     in_width;
  logic [DW-1:0]     in_height;
  logic [NS*QW-1:0]  in_qty;
  logic              busy;
  logic              finished;
  logic [CW-1:0]     result;
  logic [CW-1:0]     fail_count;
  logic [CW-1:0]     undecided_count;
  logic [1:0]        state_dbg;

  region_fit_classifier #(
    .NUM_SHAPES(NS), .QTY_W(QW), .DIM_W(DW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .shape_cells(shape_cells),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_width(in_width), .in_height(in_height), .in_qty(in_qty),
    .busy(busy), .finished(finished), .result(result),
    .fail_count(fail_count), .undecided_count(undecided_count),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0]    vw [NV];
  logic [DW-1:0]    vh [NV];
  logic [NS*QW-1:0] vq [NV];
  logic [NS*4-1:0]  cells_run;
  logic [1:0]       exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_class(input logic [DW-1:0] w, input logic [DW-1:0] h,
                                             input logic [NS*QW-1:0] q, input logic [NS*4-1:0] c);
    int sum, wt, cap, area;
    sum = 0;
    wt  = 0;
    for (int i = 0; i < NS; i++) begin
      sum += int'(q[QW*i +: QW]);
      wt  += int'(q[QW*i +: QW]) * int'(c[4*i +: 4]);
    end
    cap  = (int'(w) / 3) * (int'(h) / 3);
    area = int'(w) * int'(h);
    if (sum <= cap) return 2'd0;
    if (wt > area)  return 2'd1;
    return 2'd2;
  endfunction

  // Driver tasks
  task automatic do_start(input logic [NS*4-1:0] cells);
    cells_run   = cells;
    shape_cells = cells;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("finished_cleared", finished, 0);
  endtask

  task automatic run_regions(input int first, input int n, input bit gaps,
                             input bit poke_start, input bit send_last);
    int  i;
    int  guard;
    logic acc;
    i     = 0;
    guard = 0;
    while (i < n && guard < 20000) begin
      start       = 1'b0;
      shape_cells = cells_run;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        in_valid  = 1'b1;
        in_width  = vw[first+i];
        in_height = vh[first+i];
        in_qty    = vq[first+i];
        in_last   = send_last && (i == n - 1);
      end
      if (poke_start && i == n / 2) begin
        start       = 1'b1;
        shape_cells = 24'h999999;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        exp_q.push_back(model_class(vw[first+i], vh[first+i], vq[first+i], cells_run));
        i++;
      end
      guard++;
    end
    start       = 1'b0;
    shape_cells = cells_run;
    check("run_accepted_all", i, n);
  endtask

  // Called right after the edge that accepted in_last; in_valid is still held high.
  task automatic wait_done(input string tag, input bit check_lat);
    int k;
    k = 0;
    @(negedge clk);
    check({tag, "_ready_after_last"}, in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    k = 1;
    while (!finished && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_finished"}, finished, 1);
    check({tag, "_busy_low"}, busy, 0);
    if (check_lat) check({tag, "_latency"}, k, 3);
  endtask

  task automatic check_counts(input string tag, input int r, input int f, input int u);
    check({tag, "_result"}, result, r);
    check({tag, "_fail"}, fail_count, f);
    check({tag, "_undecided"}, undecided_count, u);
  endtask

  // Scoreboard: tally the expected queue and compare with the counters
  task automatic score_queue(input string tag, input int total);
    int r, f, u;
    logic [1:0] c;
    r = 0; f = 0; u = 0;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      if (c == 2'd0) r++;
      else if (c == 2'd1) f++;
      else u++;
    end
    check({tag, "_sum"}, result + fail_count + undecided_count, total);
    check_counts(tag, r, f, u);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_finished"}, finished, 0);
    check_counts(tag, 0, 0, 0);
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    shape_cells = '0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    in_width    = '0;
    in_height   = '0;
    in_qty      = '0;
    cells_run   = 24'h777777;

    for (int i = 0; i < 1000; i++) begin
      vw[i] = DW'($urandom_range(0, 40));
      vh[i] = DW'($urandom_range(0, 40));
      for (int s = 0; s < NS; s++) vq[i][QW*s +: QW] = QW'($urandom_range(0, 6));
    end
    vw[1000] = 12; vh[1000] = 6; vq[1000] = 48'h010101010101;
    vw[1001] = 4;  vh[1001] = 4; vq[1001] = 48'h030000000000;
    vw[1002] = 5;  vh[1002] = 5; vq[1002] = 48'h000000000002;
    vw[1003] = 2;  vh[1003] = 2; vq[1003] = 48'h000000000000;
    vw[1004] = 1;  vh[1004] = 9; vq[1004] = 48'h010101010101;
    for (int i = 1005; i < NV; i++) begin
      vw[i] = '0; vh[i] = '0; vq[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // 12x6, one of each: FIT, finished three edges after accept
    do_start(24'h777777);
    run_regions(1000, 1, 0, 0, 1);
    wait_done("fit", 1);
    check_counts("fit", 1, 0, 0);
    exp_q.delete();

    // 4x4 overweight -> FAIL; 5x5 light -> UNDECIDED (start from DONE)
    do_start(24'h777777);
    run_regions(1001, 2, 0, 0, 1);
    wait_done("fail_und", 1);
    check_counts("fail_und", 0, 1, 1);
    exp_q.delete();

    // cap=0 boundaries: 2x2 empty -> FIT, 1x9 loaded -> FAIL
    do_start(24'h777777);
    run_regions(1003, 2, 0, 0, 1);
    wait_done("cap0", 1);
    check_counts("cap0", 1, 1, 0);
    exp_q.delete();

    // Nibble above 9 used as given: 5x5 with two of a 15-cell shape -> FAIL
    do_start(24'h77777F);
    run_regions(1002, 1, 0, 0, 1);
    wait_done("nib15", 1);
    check_counts("nib15", 0, 1, 0);
    exp_q.delete();

    // 1000 back-to-back regions
    do_start(24'h777777);
    run_regions(0, 1000, 0, 0, 1);
    wait_done("bulk", 1);
    score_queue("bulk", 1000);

    // Gapped input with a stray start mid-run
    do_start(24'h777777);
    run_regions(0, 200, 1, 1, 1);
    wait_done("gaps", 0);
    score_queue("gaps", 200);

    // Reset mid-run, then a fresh run counts only its own regions
    do_start(24'h777777);
    run_regions(0, 50, 0, 0, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_zero("midreset");
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    do_start(24'h777777);
    run_regions(1000, 3, 0, 0, 1);
    wait_done("after_reset", 1);
    check_counts("after_reset", 1, 1, 1);
    exp_q.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
